// File: rtl/fifo_rd_chk.sv
// FIFO read-side burst drainer with wrapping-sequence checker for on-board debug.
// Optional idle watchdog enabled by defining RD_TIMEOUT_EN.
module fifo_rd_chk #(
  parameter int DATA_W      = 8,
  parameter int DATA_MAX    = 254,
  parameter int ERR_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              almost_full,
  input  logic              empty,
  input  logic              rd_rst_busy,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              burst_done,
  output logic [DATA_W:0]   burst_len,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic              timeout
);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  localparam logic [DATA_W-1:0] MAX_W = DATA_W'(DATA_MAX);

  state_t            state;
  logic [1:0]        af_sync;
  logic              af_s;
  logic [DATA_W:0]   burst_cnt;
  logic [DATA_W-1:0] rd_hold;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] nxt;
  logic              seeded;

  assign af_s       = af_sync[1];
  assign fifo_rd_en = (state == READ) & ~empty & ~rd_rst_busy;
  // Word is presented in the same cycle as rd_valid, then held.
  assign rd_data    = rd_valid ? fifo_dout : rd_hold;
  assign nxt        = (fifo_dout >= MAX_W) ? '0 : fifo_dout + 1'b1;

`ifdef RD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] idle_cnt;
  logic          idle_run;

  assign idle_run = ~empty & ~af_s;
`else
  logic [31:0] unused_timeout_cyc;

  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      af_sync    <= '0;
      rd_valid   <= 1'b0;
      rd_hold    <= '0;
      burst_cnt  <= '0;
      burst_len  <= '0;
      burst_done <= 1'b0;
      err_cnt    <= '0;
      err_flag   <= 1'b0;
      seeded     <= 1'b0;
      expected   <= '0;
`ifdef RD_TIMEOUT_EN
      idle_cnt   <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      af_sync    <= {af_sync[0], almost_full};
      rd_valid   <= fifo_rd_en;
      burst_done <= 1'b0;
      if (rd_valid) rd_hold <= fifo_dout;
      if (fifo_rd_en && burst_cnt != '1) burst_cnt <= burst_cnt + 1'b1;

      // Expected always follows the received word so one bad word costs at most two errors.
      if (rd_valid) begin
        seeded   <= 1'b1;
        expected <= nxt;
        if (seeded && fifo_dout != expected) begin
          err_flag <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end

`ifdef RD_TIMEOUT_EN
      timeout  <= 1'b0;
      idle_cnt <= (state == IDLE && idle_run && idle_cnt != TO_LAST) ? idle_cnt + 1'b1 : '0;
`endif

      case (state)
        IDLE: begin
          if (af_s && !rd_rst_busy) state <= READ;
`ifdef RD_TIMEOUT_EN
          else if (idle_run && idle_cnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= READ;
          end
`endif
        end
        READ: begin
          if (!rd_rst_busy && empty) begin
            state      <= DONE;
            burst_done <= 1'b1;
            burst_len  <= burst_cnt;
            burst_cnt  <= '0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
